// File: rtl/zxw_cam_match_scan.sv
// -----------------------------------------------------------------------------
// zxw_cam_match_scan
//   Downstream stage of the 16x6 CAM. When start is seen in IDLE, it captures
//   the CAM match-bit vector. It then hands out every matching entry address
//   on a valid/ready interface, one address per accepted handshake. When the
//   scan completes it pulses done for one cycle, then updates hit. match_cnt
//   counts the addresses accepted in the current or most recent scan.
//
//   Build option:
//     ZXW_SCAN_HIGH_FIRST_EN  defined   -> highest set bit is emitted first
//                             undefined -> lowest set bit is emitted first
//   Ports, FSM, counts and timing are the same in both builds.
// -----------------------------------------------------------------------------
module zxw_cam_match_scan #(
    parameter int N_ENT = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_ENT-1:0] mbits,
    input  logic             idx_ready,
    output logic             idx_valid,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_ENT-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;

    logic [IDX_W-1:0] enc_idx;       // selected entry inside pending_q
    logic [N_ENT-1:0] sel_mask;      // one-hot of enc_idx
    logic [N_ENT-1:0] pending_left;  // pending_q with the selected entry removed
    logic             accept;        // address handshake completes this cycle

    // Priority-encode the next address to hand out from the captured vector.
    always_comb begin
        // NOTE: every signal assigned in always_comb receives a default first,
        // so no path through the block leaves it unassigned and no latch is inferred.
        enc_idx = '0;
`ifdef ZXW_SCAN_HIGH_FIRST_EN
        // Ascending walk, last hit wins -> highest set bit.
        for (int i = 0; i < N_ENT; i++) begin
            if (pending_q[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
`else
        // Descending walk, last hit wins -> lowest set bit.
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                enc_idx = IDX_W'(i);
            end
        end
`endif
        sel_mask          = '0;
        sel_mask[enc_idx] = 1'b1;
        pending_left      = pending_q & ~sel_mask;
    end

    assign accept = (state_q == ST_SCAN) && idx_ready;

    // Compute the next state and the next values of pending, count and hit.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pending_d = mbits;
                    cnt_d     = '0;
                    hit_d     = 1'b0;
                    state_d   = (mbits != '0) ? ST_SCAN : ST_DONE;
                end
            end

            ST_SCAN: begin
                // Without a handshake, pending and the count are held. That
                // keeps idx stable until the consumer accepts it.
                if (accept) begin
                    pending_d = pending_left;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (pending_left == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                hit_d   = (cnt_q != '0);
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            // NOTE: pending is data, not control. Its value in IDLE is never
            // observed, but it is still reset so that idx and the encoder never
            // see stale match bits from an abandoned scan.
            pending_q <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Each
            // register then samples pre-edge values, independent of statement order.
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
        end
    end

    // Output decode. idx is forced to zero whenever no address is offered.
    always_comb begin
        idx_valid = (state_q == ST_SCAN);
        idx       = idx_valid ? enc_idx : '0;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        hit       = hit_q;
        match_cnt = cnt_q;
    end

    // Design invariants: SCAN always has an address to offer, and done lasts one cycle.
    a_scan_nonempty : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_SCAN) |-> (pending_q != '0));
    a_done_single   : assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

endmodule
